// File: rtl/ctrl_vent_pkg.sv
// Shared definitions for the ventilation controller: FSM codes, default tunables
// and the BCD digit check applied to every captured temperature sample.
package ctrl_vent_pkg;

  localparam logic [1:0] ESPERA  = 2'd0;
  localparam logic [1:0] CAPTURA = 2'd1;
  localparam logic [1:0] EVALUA  = 2'd2;
  localparam logic [1:0] ALARMA  = 2'd3;

  localparam int N_PRES_DEF   = 3;
  localparam int N_VENT_DEF   = 2;
  localparam int T_MIN_ON_DEF = 10;
  localparam int T_BUZZ_DEF   = 5;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/debounce_cnt.sv
// Saturating counter of consecutive accepted samples; hit is combinational and
// flags the accepted sample that reaches N. Cleared by any opposite sample.
module debounce_cnt #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sample,
  output logic hit
);

  localparam int W = ($clog2(N + 1) < 2) ? 2 : $clog2(N + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      if (!sample) begin
        cnt <= '0;
      end else if (cnt < W'(N)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign hit = en && sample && (cnt >= W'(N - 1));

endmodule

// File: rtl/control_ventilacion.sv
// Presence/fan/alarm controller: samples on tick_1hz, evaluates 2 cycles later;
// ticks arriving while a sample is in flight are dropped, never queued.
module control_ventilacion
  import ctrl_vent_pkg::*;
#(
  parameter int N_PRES   = N_PRES_DEF,
  parameter int N_VENT   = N_VENT_DEF,
  parameter int T_MIN_ON = T_MIN_ON_DEF,
  parameter int T_BUZZ   = T_BUZZ_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic [7:0] temp_amb,
  input  logic [7:0] temp_corp,
  output logic [7:0] temp_amb_q,
  output logic [7:0] temp_corp_q,
  input  logic       alarma_eval,
  input  logic       vent_eval,
  input  logic       pres_eval,
  input  logic       ack,
  output logic       presencia,
  output logic       ventilador,
  output logic       alarma,
  output logic       buzzer,
  output logic       err_bcd,
  output logic [1:0] estado
);

  localparam int MW = (T_MIN_ON < 2) ? 1 : $clog2(T_MIN_ON + 1);
  localparam int BW = (T_BUZZ < 2) ? 1 : $clog2(T_BUZZ + 1);

  logic [1:0]    state;
  logic [1:0]    phase;
  logic [MW-1:0] min_cnt;
  logic [BW-1:0] buzz_cnt;
  logic          last_alarm;
  logic          eval_now, valid, upd, eff_last, sample_now;
  logic          pres_on, pres_off, vent_hit;

  // ALARMA runs its own capture/evaluate cadence through phase 0 -> 1 -> 2
  assign sample_now = tick_1hz && ((state == ESPERA) || (state == ALARMA && phase == 2'd0));
  assign eval_now   = (state == EVALUA) || (state == ALARMA && phase == 2'd2);
  assign valid      = bcd_ok(temp_amb_q) && bcd_ok(temp_corp_q);
  assign upd        = eval_now && valid;
  assign eff_last   = upd ? alarma_eval : last_alarm;
  assign estado     = state;

  debounce_cnt #(.N(N_PRES)) u_pres_set (
    .clk(clk), .reset_n(reset_n), .en(upd), .sample(pres_eval), .hit(pres_on)
  );

  debounce_cnt #(.N(N_PRES)) u_pres_clr (
    .clk(clk), .reset_n(reset_n), .en(upd), .sample(!pres_eval), .hit(pres_off)
  );

  debounce_cnt #(.N(N_VENT)) u_vent (
    .clk(clk), .reset_n(reset_n), .en(upd), .sample(vent_eval), .hit(vent_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ESPERA;
      phase       <= 2'd0;
      temp_amb_q  <= 8'h00;
      temp_corp_q <= 8'h00;
      presencia   <= 1'b0;
      ventilador  <= 1'b0;
      alarma      <= 1'b0;
      buzzer      <= 1'b0;
      err_bcd     <= 1'b0;
      min_cnt     <= '0;
      buzz_cnt    <= '0;
      last_alarm  <= 1'b0;
    end else begin
      err_bcd <= eval_now && !valid;

      if (sample_now) begin
        temp_amb_q  <= temp_amb;
        temp_corp_q <= temp_corp;
      end

      if (upd) begin
        last_alarm <= alarma_eval;
        if (pres_on) begin
          presencia <= 1'b1;
        end else if (pres_off) begin
          presencia <= 1'b0;
        end
      end

      // Min-on countdown; a fresh fan start below reloads it
      if (tick_1hz && ventilador && min_cnt != '0) begin
        min_cnt <= min_cnt - 1'b1;
      end
      if (upd) begin
        if (vent_hit && !ventilador) begin
          ventilador <= 1'b1;
          min_cnt    <= MW'(T_MIN_ON);
        end else if (ventilador && !vent_eval && min_cnt == '0) begin
          ventilador <= 1'b0;
        end
      end

      if (tick_1hz && buzzer && buzz_cnt != '0) begin
        buzz_cnt <= buzz_cnt - 1'b1;
        if (buzz_cnt == BW'(1)) begin
          buzzer <= 1'b0;
        end
      end

      case (state)
        ESPERA: begin
          if (tick_1hz) begin
            state <= CAPTURA;
          end
        end
        CAPTURA: state <= EVALUA;
        EVALUA: begin
          if (upd && alarma_eval) begin
            state      <= ALARMA;
            phase      <= 2'd0;
            alarma     <= 1'b1;
            buzzer     <= (T_BUZZ != 0);
            buzz_cnt   <= BW'(T_BUZZ);
            last_alarm <= 1'b1;
          end else begin
            state <= ESPERA;
          end
        end
        ALARMA: begin
          if (ack) begin
            buzzer <= 1'b0;
          end
          // An evaluation in this very cycle decides the exit, not the stale flag
          if (ack && !eff_last) begin
            state    <= ESPERA;
            phase    <= 2'd0;
            alarma   <= 1'b0;
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
          end else begin
            case (phase)
              2'd0:    if (tick_1hz) phase <= 2'd1;
              2'd1:    phase <= 2'd2;
              default: phase <= 2'd0;
            endcase
          end
        end
        default: state <= ESPERA;
      endcase
    end
  end

endmodule

// File: tb/tb_control_ventilacion.sv
// Directed bench for control_ventilacion with a simple threshold evaluator model
// (alarm >= 38, presence >= 36, ventilation when ambient >= 25, all BCD).
module tb_control_ventilacion;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [7:0] temp_amb = 8'h20;
  logic [7:0] temp_corp = 8'h30;
  logic [7:0] temp_amb_q, temp_corp_q;
  logic       alarma_eval, vent_eval, pres_eval;
  logic       ack = 1'b0;
  logic       presencia, ventilador, alarma, buzzer, err_bcd;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alarma_eval = (temp_corp_q >= 8'h38);
  assign pres_eval   = (temp_corp_q >= 8'h36);
  assign vent_eval   = (temp_amb_q >= 8'h25);

  control_ventilacion dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz),
    .temp_amb(temp_amb), .temp_corp(temp_corp),
    .temp_amb_q(temp_amb_q), .temp_corp_q(temp_corp_q),
    .alarma_eval(alarma_eval), .vent_eval(vent_eval), .pres_eval(pres_eval),
    .ack(ack), .presencia(presencia), .ventilador(ventilador),
    .alarma(alarma), .buzzer(buzzer), .err_bcd(err_bcd), .estado(estado)
  );

  // Tick for one edge, then return just after the evaluation edge
  task automatic tick_eval();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({presencia, ventilador, alarma, buzzer, err_bcd} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000", {presencia, ventilador, alarma, buzzer, err_bcd});
    end
    checks++;
    if (estado !== 2'd0) begin
      errors++; $display("FAIL reset_estado got %0d exp 0", estado);
    end
    checks++;
    if ({temp_amb_q, temp_corp_q} !== 16'h0000) begin
      errors++; $display("FAIL reset_temps got %h exp 0000", {temp_amb_q, temp_corp_q});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_presence();
    temp_amb = 8'h20; temp_corp = 8'h37;
    tick_eval();
    tick_eval();
    checks++;
    if (presencia !== 1'b0) begin
      errors++; $display("FAIL pres_after_2 got %b exp 0", presencia);
    end
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    checks++;
    if (estado !== 2'd1 || temp_corp_q !== 8'h37) begin
      errors++; $display("FAIL capture got estado %0d q %h exp 1 37", estado, temp_corp_q);
    end
    @(negedge clk);
    checks++;
    if (estado !== 2'd2 || presencia !== 1'b0) begin
      errors++; $display("FAIL evalua got estado %0d pres %b exp 2 0", estado, presencia);
    end
    @(negedge clk);
    checks++;
    if (presencia !== 1'b1 || estado !== 2'd0) begin
      errors++; $display("FAIL pres_set got pres %b estado %0d exp 1 0", presencia, estado);
    end
  endtask

  task automatic test_tick_ignored();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk);
    @(negedge clk) tick_1hz = 1'b0;
    checks++;
    if (estado !== 2'd2) begin
      errors++; $display("FAIL tick_in_captura got estado %0d exp 2", estado);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (estado !== 2'd0) begin
      errors++; $display("FAIL tick_not_queued got estado %0d exp 0", estado);
    end
  endtask

  task automatic test_fan();
    temp_amb = 8'h26;
    tick_eval();
    checks++;
    if (ventilador !== 1'b0) begin
      errors++; $display("FAIL fan_after_1 got %b exp 0", ventilador);
    end
    tick_eval();
    checks++;
    if (ventilador !== 1'b1) begin
      errors++; $display("FAIL fan_start got %b exp 1", ventilador);
    end
    temp_amb = 8'h20;
    for (int k = 3; k <= 11; k++) begin
      tick_eval();
      checks++;
      if (ventilador !== 1'b1) begin
        errors++; $display("FAIL fan_hold tick %0d got %b exp 1", k, ventilador);
      end
    end
    tick_eval();
    checks++;
    if (ventilador !== 1'b0) begin
      errors++; $display("FAIL fan_release got %b exp 0", ventilador);
    end
  endtask

  task automatic test_bcd();
    temp_amb = 8'h26;
    tick_eval();
    checks++;
    if (err_bcd !== 1'b0 || ventilador !== 1'b0) begin
      errors++; $display("FAIL bcd_valid got err %b fan %b exp 0 0", err_bcd, ventilador);
    end
    temp_amb = 8'h2A;
    tick_eval();
    checks++;
    if (err_bcd !== 1'b1) begin
      errors++; $display("FAIL bcd_pulse got %b exp 1", err_bcd);
    end
    checks++;
    if (ventilador !== 1'b0 || presencia !== 1'b1 || estado !== 2'd0) begin
      errors++;
      $display("FAIL bcd_unchanged got fan %b pres %b estado %0d exp 0 1 0", ventilador, presencia, estado);
    end
    @(negedge clk);
    checks++;
    if (err_bcd !== 1'b0) begin
      errors++; $display("FAIL bcd_one_cycle got %b exp 0", err_bcd);
    end
    temp_amb = 8'h26;
    tick_eval();
    checks++;
    if (ventilador !== 1'b1) begin
      errors++; $display("FAIL bcd_count_kept got fan %b exp 1", ventilador);
    end
  endtask

  task automatic test_alarm();
    temp_corp = 8'h38;
    tick_eval();
    checks++;
    if (alarma !== 1'b1 || buzzer !== 1'b1 || estado !== 2'd3) begin
      errors++; $display("FAIL alarm_entry got a %b b %b estado %0d exp 1 1 3", alarma, buzzer, estado);
    end
    for (int k = 1; k <= 4; k++) tick_eval();
    checks++;
    if (buzzer !== 1'b1 || ventilador !== 1'b1) begin
      errors++; $display("FAIL buzz_tick4 got b %b fan %b exp 1 1", buzzer, ventilador);
    end
    tick_eval();
    checks++;
    if (buzzer !== 1'b0 || alarma !== 1'b1 || estado !== 2'd3) begin
      errors++; $display("FAIL buzz_tick5 got b %b a %b estado %0d exp 0 1 3", buzzer, alarma, estado);
    end
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    checks++;
    if (alarma !== 1'b1 || estado !== 2'd3) begin
      errors++; $display("FAIL ack_hot got a %b estado %0d exp 1 3", alarma, estado);
    end
    temp_corp = 8'h36;
    tick_eval();
    checks++;
    if (alarma !== 1'b1 || estado !== 2'd3) begin
      errors++; $display("FAIL cool_no_ack got a %b estado %0d exp 1 3", alarma, estado);
    end
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    checks++;
    if (alarma !== 1'b0 || buzzer !== 1'b0 || estado !== 2'd0) begin
      errors++; $display("FAIL alarm_exit got a %b b %b estado %0d exp 0 0 0", alarma, buzzer, estado);
    end
    checks++;
    if (presencia !== 1'b1 || ventilador !== 1'b1) begin
      errors++; $display("FAIL exit_keeps got pres %b fan %b exp 1 1", presencia, ventilador);
    end
  endtask

  task automatic test_ack_cases();
    temp_corp = 8'h38;
    tick_eval();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    checks++;
    if (buzzer !== 1'b0 || alarma !== 1'b1) begin
      errors++; $display("FAIL ack_buzzer got b %b a %b exp 0 1", buzzer, alarma);
    end
    temp_corp = 8'h36;
    tick_eval();
    temp_corp = 8'h38;
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    checks++;
    if (alarma !== 1'b1 || estado !== 2'd3) begin
      errors++; $display("FAIL ack_with_eval got a %b estado %0d exp 1 3", alarma, estado);
    end
  endtask

  task automatic test_reset_in_alarm();
    @(negedge clk);
    checks++;
    if (estado !== 2'd3 || ventilador !== 1'b1) begin
      errors++; $display("FAIL pre_reset got estado %0d fan %b exp 3 1", estado, ventilador);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({presencia, ventilador, alarma, buzzer, err_bcd} !== 5'b0 || estado !== 2'd0) begin
      errors++;
      $display("FAIL reset_alarm got %b estado %0d exp 00000 0", {presencia, ventilador, alarma, buzzer, err_bcd}, estado);
    end
    reset_n = 1'b1;
    temp_corp = 8'h37;
    tick_eval();
    checks++;
    if (presencia !== 1'b0) begin
      errors++; $display("FAIL counters_cleared got pres %b exp 0", presencia);
    end
  endtask

  initial begin
    test_reset();
    test_presence();
    test_tick_ignored();
    test_fan();
    test_bcd();
    test_alarm();
    test_ack_cases();
    test_reset_in_alarm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
